// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - sync hunt, polarity resolution and payload byte packing for the Rx path
module rx_deframer #(
   parameter logic [15:0] SYNC_WORD   = 16'hEB90,
   parameter int          SYNC_LEN    = 16,
   parameter int          MAX_ERR     = 1,
   parameter int          FRAME_BYTES = 32
) (
   input  logic       clk_16M384,
   input  logic       rst_16M384,
   input  logic [3:0] MODE_CTRL,
   input  logic [1:0] Rx_bits,
   input  logic       Rx_vld,
   output logic [7:0] data_tdata,
   output logic       data_tvalid,
   input  logic       data_tready,
   output logic       data_tlast,
   output logic       data_tuser,
   output logic       sync_lock,
   output logic       polarity_inv,
   output logic       overflow
);

   localparam logic [3:0]  MODE_QPSK = 4'b0010;
   localparam logic [3:0]  MODE_MIX  = 4'b0100;
   localparam logic [15:0] SYNC_MASK = (SYNC_LEN >= 16) ? 16'hFFFF
                                       : 16'((32'd1 << SYNC_LEN) - 32'd1);
   localparam logic [7:0]  LAST_IDX  = 8'(FRAME_BYTES - 1);

   typedef enum logic {ST_HUNT, ST_PAYLOAD} state_t;

   state_t      state_q;
   logic [15:0] shreg_q;
   logic [3:0]  mode_q;
   logic        pol_q;
   logic        hold_q;
   logic [7:0]  acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  dat_q;
   logic        vld_q, user_q, last_q, ovf_q;

   logic        hunt_qpsk;
   logic [15:0] sh1, sh2;
   logic [1:0]  m1, m2;
   logic        p_in_valid, p_two, p_pol, p_bit;
   logic [1:0]  p_bits;
   logic        byte_done, byte_first, byte_last, frame_done;
   logic [7:0]  byte_val;
   logic        accept;

   function automatic int popcount16(input logic [15:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) n += int'(v[i]);
      return n;
   endfunction

   // {match, inverted}; the non-inverted match wins when both are within range
   function automatic logic [1:0] hdr_match(input logic [15:0] sh);
      int d;
      int di;
      d  = popcount16((sh ^ SYNC_WORD) & SYNC_MASK);
      di = popcount16((~sh ^ SYNC_WORD) & SYNC_MASK);
      if (d <= MAX_ERR) return 2'b10;
      else if (di <= MAX_ERR) return 2'b11;
      else return 2'b00;
   endfunction

   // Header window after the first and (QPSK only) second bit of this strobe
   always_comb begin
      hunt_qpsk = (MODE_CTRL == MODE_QPSK);
      sh1       = {shreg_q[14:0], hunt_qpsk ? Rx_bits[1] : Rx_bits[0]};
      m1        = hdr_match(sh1);
      sh2       = {sh1[14:0], Rx_bits[0]};
      m2        = hdr_match(sh2);
   end

   // Payload bit packer; a pair may straddle a byte boundary after a mid-pair lock
   always_comb begin
      p_in_valid = 1'b0;
      p_two      = 1'b0;
      p_bits     = 2'b00;
      p_pol      = pol_q;
      p_bit      = 1'b0;
      if (state_q == ST_PAYLOAD) begin
         p_in_valid = Rx_vld;
         p_two      = (mode_q == MODE_QPSK) || (mode_q == MODE_MIX);
         p_bits     = p_two ? Rx_bits : {Rx_bits[0], 1'b0};
      end else if (Rx_vld && !hold_q && hunt_qpsk && m1[1]) begin
         // lock on the first bit of a pair: the second bit opens the payload
         p_in_valid = 1'b1;
         p_bits     = {Rx_bits[0], 1'b0};
         p_pol      = m1[0];
      end
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      byte_done  = 1'b0;
      byte_val   = acc_q;
      byte_first = 1'b0;
      byte_last  = 1'b0;
      frame_done = 1'b0;
      if (p_in_valid) begin
         for (int i = 0; i < 2; i++) begin
            if ((i == 0 || p_two) && !frame_done) begin
               p_bit = (i == 0) ? p_bits[1] : p_bits[0];
               acc_d = {acc_d[6:0], p_bit ^ p_pol};
               if (cnt_d == 3'd7) begin
                  byte_done  = 1'b1;
                  byte_val   = acc_d;
                  byte_first = (idx_d == 8'd0);
                  byte_last  = (idx_d == LAST_IDX);
                  cnt_d      = 3'd0;
                  if (idx_d == LAST_IDX) frame_done = 1'b1;
                  else idx_d = idx_d + 8'd1;
               end else begin
                  cnt_d = cnt_d + 3'd1;
               end
            end
         end
      end
      accept = vld_q && data_tready;
   end

   // Hunt/payload FSM plus the single-entry output register
   always_ff @(posedge clk_16M384) begin
      if (rst_16M384) begin
         state_q <= ST_HUNT;
         shreg_q <= 16'd0;
         mode_q  <= 4'd0;
         pol_q   <= 1'b0;
         hold_q  <= 1'b0;
         acc_q   <= 8'd0;
         cnt_q   <= 3'd0;
         idx_q   <= 8'd0;
         dat_q   <= 8'd0;
         vld_q   <= 1'b0;
         user_q  <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         hold_q <= 1'b0;
         case (state_q)
            ST_HUNT: begin
               // the cycle right after a frame ends ignores Rx_vld so frames never overlap
               if (Rx_vld && !hold_q) begin
                  if (hunt_qpsk) begin
                     shreg_q <= sh2;
                     if (m1[1]) begin
                        state_q <= ST_PAYLOAD;
                        pol_q   <= m1[0];
                        mode_q  <= MODE_CTRL;
                     end else if (m2[1]) begin
                        state_q <= ST_PAYLOAD;
                        pol_q   <= m2[0];
                        mode_q  <= MODE_CTRL;
                     end
                  end else begin
                     shreg_q <= sh1;
                     if (m1[1]) begin
                        state_q <= ST_PAYLOAD;
                        pol_q   <= m1[0];
                        mode_q  <= MODE_CTRL;
                     end
                  end
               end
            end
            default: begin
               if (frame_done) begin
                  state_q <= ST_HUNT;
                  shreg_q <= 16'd0;
                  hold_q  <= 1'b1;
                  acc_q   <= 8'd0;
                  cnt_q   <= 3'd0;
                  idx_q   <= 8'd0;
               end
            end
         endcase
         if (byte_done) begin
            if (!vld_q || accept) begin
               dat_q  <= byte_val;
               vld_q  <= 1'b1;
               user_q <= byte_first;
               last_q <= byte_last;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (accept) begin
            vld_q <= 1'b0;
         end
      end
   end

   assign data_tdata   = dat_q;
   assign data_tvalid  = vld_q;
   assign data_tuser   = user_q;
   assign data_tlast   = last_q;
   assign sync_lock    = (state_q == ST_PAYLOAD);
   assign polarity_inv = pol_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_rx_deframer.sv
// tb/tb_rx_deframer.sv - directed table-driven bench for rx_deframer
module tb_rx_deframer;

   localparam logic [3:0] M_BPSK = 4'b0001;
   localparam logic [3:0] M_QPSK = 4'b0010;
   localparam logic [3:0] M_MIX  = 4'b0100;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] MODE_CTRL;
   logic [1:0] Rx_bits;
   logic       Rx_vld;
   logic [7:0] data_tdata;
   logic       data_tvalid;
   logic       data_tready;
   logic       data_tlast;
   logic       data_tuser;
   logic       sync_lock;
   logic       polarity_inv;
   logic       overflow;

   always #5 clk = ~clk;

   rx_deframer #(
      .SYNC_WORD(16'hEB90), .SYNC_LEN(16), .MAX_ERR(1), .FRAME_BYTES(2)
   ) dut (
      .clk_16M384(clk), .rst_16M384(rst), .MODE_CTRL(MODE_CTRL),
      .Rx_bits(Rx_bits), .Rx_vld(Rx_vld),
      .data_tdata(data_tdata), .data_tvalid(data_tvalid), .data_tready(data_tready),
      .data_tlast(data_tlast), .data_tuser(data_tuser),
      .sync_lock(sync_lock), .polarity_inv(polarity_inv), .overflow(overflow)
   );

   int checks   = 0;
   int failures = 0;

   logic [9:0] cap_mem [0:255];
   int         cap_n    = 0;
   int         lock_cnt = 0;

   // Byte sink monitor: records {tuser, tlast, tdata} for every handshake
   always @(negedge clk) begin
      if (data_tvalid && data_tready) begin
         cap_mem[cap_n[7:0]] <= {data_tuser, data_tlast, data_tdata};
         cap_n <= cap_n + 1;
      end
      if (sync_lock) lock_cnt <= lock_cnt + 1;
   end

   typedef struct {
      string      name;
      logic [3:0] mode;
      logic       pad;
      logic [15:0] hdr;
      logic [7:0] s0;
      logic [7:0] s1;
      int         exp_n;
      logic       exp_pol;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst    = 1'b1;
      Rx_vld = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_stream(input logic [3:0] mode, input logic pad, input logic [15:0] hdr,
                             input logic [7:0] s0, input logic [7:0] s1);
      bit hb[$];
      bit pb[$];
      MODE_CTRL = mode;
      if (pad) hb.push_back(1'b0);
      for (int i = 15; i >= 0; i--) hb.push_back(hdr[i]);
      for (int i = 7; i >= 0; i--) pb.push_back(s0[i]);
      for (int i = 7; i >= 0; i--) pb.push_back(s1[i]);
      if (mode == M_QPSK) begin
         foreach (pb[i]) hb.push_back(pb[i]);
         if (hb.size() % 2 == 1) hb.push_back(1'b0);
         for (int i = 0; i < hb.size(); i += 2) begin
            Rx_bits = {hb[i], hb[i+1]};
            Rx_vld  = 1'b1;
            step();
         end
      end else if (mode == M_MIX) begin
         foreach (hb[i]) begin
            Rx_bits = {1'b0, hb[i]};
            Rx_vld  = 1'b1;
            step();
         end
         for (int i = 0; i < pb.size(); i += 2) begin
            Rx_bits = {pb[i], pb[i+1]};
            Rx_vld  = 1'b1;
            step();
         end
      end else begin
         foreach (pb[i]) hb.push_back(pb[i]);
         foreach (hb[i]) begin
            Rx_bits = {1'b0, hb[i]};
            Rx_vld  = 1'b1;
            step();
         end
      end
      Rx_vld  = 1'b0;
      Rx_bits = 2'b00;
      repeat (4) step();
   endtask

   task automatic check_frame(input string nm, input int base, input int exp_n,
                              input logic [7:0] e0, input logic [7:0] e1);
      check({nm, "_count"}, 32'(cap_n - base), 32'(exp_n));
      if (exp_n == 2) begin
         check({nm, "_byte0"}, {22'd0, cap_mem[base[7:0]]}, {22'd0, 2'b10, e0});
         check({nm, "_byte1"}, {22'd0, cap_mem[8'(base + 1)]}, {22'd0, 2'b01, e1});
      end
   endtask

   initial begin
      int base;
      int lbase;
      logic [15:0] hw;
      logic [15:0] pw;

      vecs[0] = '{"bpsk_plain", M_BPSK, 1'b0, 16'hEB90, 8'hA5, 8'h3C, 2, 1'b0, 8'hA5, 8'h3C};
      vecs[1] = '{"bpsk_inv",   M_BPSK, 1'b0, 16'h146F, 8'h5A, 8'hC3, 2, 1'b1, 8'hA5, 8'h3C};
      vecs[2] = '{"bpsk_1err",  M_BPSK, 1'b0, 16'hEB91, 8'h12, 8'h34, 2, 1'b0, 8'h12, 8'h34};
      vecs[3] = '{"bpsk_2err",  M_BPSK, 1'b0, 16'hEB93, 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00};
      vecs[4] = '{"qpsk_plain", M_QPSK, 1'b0, 16'hEB90, 8'h81, 8'h7E, 2, 1'b0, 8'h81, 8'h7E};
      vecs[5] = '{"qpsk_mid",   M_QPSK, 1'b1, 16'hEB90, 8'h81, 8'h7E, 2, 1'b0, 8'h81, 8'h7E};
      vecs[6] = '{"mix_plain",  M_MIX,  1'b0, 16'hEB90, 8'h81, 8'h7E, 2, 1'b0, 8'h81, 8'h7E};
      vecs[7] = '{"qpsk_inv",   M_QPSK, 1'b1, 16'h146F, 8'h39, 8'hF0, 2, 1'b1, 8'hC6, 8'h0F};

      rst         = 1'b1;
      MODE_CTRL   = M_BPSK;
      Rx_bits     = 2'b00;
      Rx_vld      = 1'b0;
      data_tready = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("reset_outputs",
            {18'd0, data_tdata, data_tvalid, data_tlast, data_tuser, sync_lock, polarity_inv, overflow},
            32'd0);

      for (int v = 0; v < 8; v++) begin
         apply_reset();
         data_tready = 1'b1;
         base  = cap_n;
         lbase = lock_cnt;
         run_stream(vecs[v].mode, vecs[v].pad, vecs[v].hdr, vecs[v].s0, vecs[v].s1);
         check_frame(vecs[v].name, base, vecs[v].exp_n, vecs[v].e0, vecs[v].e1);
         check({vecs[v].name, "_locked"}, 32'(lock_cnt > lbase), 32'(vecs[v].exp_n > 0));
         check({vecs[v].name, "_pol"}, 32'(polarity_inv), 32'(vecs[v].exp_pol));
         check({vecs[v].name, "_ovf"}, 32'(overflow), 32'd0);
         check({vecs[v].name, "_hunt"}, 32'(sync_lock), 32'd0);
      end

      // Back-pressure: first byte held, second dropped, overflow sticky until reset
      apply_reset();
      MODE_CTRL   = M_BPSK;
      data_tready = 1'b0;
      base        = cap_n;
      hw          = 16'hEB90;
      pw          = 16'hA53C;
      for (int i = 15; i >= 0; i--) begin
         Rx_bits = {1'b0, hw[i]};
         Rx_vld  = 1'b1;
         if (i == 0) check("lock_before_last_bit", 32'(sync_lock), 32'd0);
         step();
      end
      check("lock_after_last_bit", 32'(sync_lock), 32'd1);
      for (int i = 15; i >= 0; i--) begin
         Rx_bits = {1'b0, pw[i]};
         Rx_vld  = 1'b1;
         step();
      end
      Rx_vld = 1'b0;
      step();
      check("ovf_held_byte", {19'd0, data_tvalid, data_tuser, data_tlast, data_tdata},
            {19'd0, 1'b1, 1'b1, 1'b0, 8'hA5});
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_back_to_hunt", 32'(sync_lock), 32'd0);
      data_tready = 1'b1;
      step();
      data_tready = 1'b0;
      check("ovf_drained", 32'(data_tvalid), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check_frame("ovf_sink", base, 1, 8'h00, 8'h00);
      check("ovf_sink_byte", {22'd0, cap_mem[base[7:0]]}, {22'd0, 2'b10, 8'hA5});
      apply_reset();
      check("ovf_cleared_by_reset", 32'(overflow), 32'd0);

      // Reset 12 bits into the payload, then a clean frame
      apply_reset();
      MODE_CTRL   = M_BPSK;
      data_tready = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         Rx_bits = {1'b0, hw[i]};
         Rx_vld  = 1'b1;
         step();
      end
      for (int i = 15; i >= 4; i--) begin
         Rx_bits = {1'b0, pw[i]};
         Rx_vld  = 1'b1;
         step();
      end
      Rx_vld = 1'b0;
      check("midrst_pending_byte", 32'(data_tvalid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_outputs",
            {18'd0, data_tdata, data_tvalid, data_tlast, data_tuser, sync_lock, polarity_inv, overflow},
            32'd0);
      data_tready = 1'b1;
      base        = cap_n;
      run_stream(M_BPSK, 1'b0, 16'hEB90, 8'hA5, 8'h3C);
      check_frame("midrst_clean", base, 2, 8'hA5, 8'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
